// File: rtl/pipeline_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_fetch_queue_if
// Purpose  : Fetch-queue signal bundle between memory bus / decode and the queue
// Revision : 1.0
// ============================================================================
interface pipeline_fetch_queue_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] bus_in;
    logic             bus_request;
    logic             fetch_suppress;
    logic             flush;
    logic             flag_pcraflip;
    logic             instr_ready;
    logic [WIDTH-1:0] instruction_out;
    logic             instr_valid;
    logic [LVL_W-1:0] level;
    logic             inc_pcra0;
    logic             inc_pcra1;

    modport master (
        output bus_in, bus_request, fetch_suppress, flush, flag_pcraflip, instr_ready,
        input  instruction_out, instr_valid, level, inc_pcra0, inc_pcra1
    );

    modport slave (
        input  bus_in, bus_request, fetch_suppress, flush, flag_pcraflip, instr_ready,
        output instruction_out, instr_valid, level, inc_pcra0, inc_pcra1
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_fetch_queue
// Purpose  : DEPTH-entry instruction prefetch FIFO with PCRA0/PCRA1 step pulses.
//            Optional macro PIPELINE_FETCH_BYPASS_EN: zero-latency empty bypass.
// Revision : 1.0
// ============================================================================
module pipeline_fetch_queue #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] NOP_OPCODE = '0
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    pipeline_fetch_queue_if.slave      fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    logic             full;
    logic             empty;
    logic             fetch_ok;
    logic             push;
    logic             pop;
    logic             valid;
    logic [WIDTH-1:0] head;

    always_comb begin
        full     = (level_q == LVL_W'(DEPTH));
        empty    = (level_q == '0);
        fetch_ok = !reset && !fq.flush && !fq.bus_request && !fq.fetch_suppress && !full;
        head     = mem_q[rd_ptr_q];
        // Queue-side pop only; the bypassed byte never enters the array.
        pop      = !reset && !empty && fq.instr_ready && !fq.flush;
`ifdef PIPELINE_FETCH_BYPASS_EN
        push     = fetch_ok && !(empty && fq.instr_ready);
        valid    = (!reset && !empty) || fetch_ok;
        if (empty && fetch_ok)
            fq.instruction_out = fq.bus_in;
        else
            fq.instruction_out = valid ? head : NOP_OPCODE;
`else
        push     = fetch_ok;
        valid    = !reset && !empty;
        fq.instruction_out = valid ? head : NOP_OPCODE;
`endif
        fq.instr_valid = valid;
        fq.level       = reset ? '0 : level_q;
        fq.inc_pcra0   = fetch_ok && !fq.flag_pcraflip;
        fq.inc_pcra1   = fetch_ok &&  fq.flag_pcraflip;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)
            level_d = level_q + LVL_W'(1);
        else if (pop && !push)
            level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || fq.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= fq.bus_in;
    end
endmodule
`default_nettype wire

// File: tb/tb_pipeline_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_fetch_queue
// Purpose  : Directed self-checking bench for pipeline_fetch_queue (DEPTH=4)
// Revision : 1.0
// ============================================================================
module tb_pipeline_fetch_queue;
`ifdef PIPELINE_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pipeline_fetch_queue_if #(.WIDTH(8), .DEPTH(4)) ifc ();

    pipeline_fetch_queue #(.WIDTH(8), .DEPTH(4), .NOP_OPCODE(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed bundle: {valid, instruction_out, level, inc_pcra0, inc_pcra1}
    logic [13:0] obs;
    assign obs = {ifc.instr_valid, ifc.instruction_out, ifc.level, ifc.inc_pcra0, ifc.inc_pcra1};

    task automatic drive(input logic rst, input logic fl, input logic breq, input logic fsup,
                         input logic flip, input logic rdy, input logic [7:0] bus);
        reset              = rst;
        ifc.flush          = fl;
        ifc.bus_request    = breq;
        ifc.fetch_suppress = fsup;
        ifc.flag_pcraflip  = flip;
        ifc.instr_ready    = rdy;
        ifc.bus_in         = bus;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
            @(negedge clk);
            checks++;
            if (obs !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL reset[%0d]: got %h expected %h", k, obs, {1'b0, 8'h00, 3'd0, 1'b0, 1'b0});
            end
            next_cycle();
        end
    endtask

    task automatic test_fill_stall();
        logic [7:0]  bus [5];
        logic [13:0] exp_v [5];
        bus   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        exp_v = '{{BYP, BYP ? 8'h10 : 8'h00, 3'd0, 1'b1, 1'b0},
                  {1'b1, 8'h10, 3'd1, 1'b1, 1'b0},
                  {1'b1, 8'h10, 3'd2, 1'b1, 1'b0},
                  {1'b1, 8'h10, 3'd3, 1'b1, 1'b0},
                  {1'b1, 8'h10, 3'd4, 1'b0, 1'b0}};
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bus[k]);
            @(negedge clk);
            checks++;
            if (obs !== exp_v[k]) begin
                failures++;
                $display("FAIL fill_stall[%0d]: got %h expected %h", k, obs, exp_v[k]);
            end
            next_cycle();
        end
    endtask

    task automatic test_drain_wrap();
        logic [7:0]  bus [6];
        logic [13:0] exp_v [6];
        bus   = '{8'h20, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
        exp_v = '{{1'b1, 8'h10, 3'd4, 1'b0, 1'b0},
                  {1'b1, 8'h11, 3'd3, 1'b1, 1'b0},
                  {1'b1, 8'h12, 3'd3, 1'b1, 1'b0},
                  {1'b1, 8'h13, 3'd3, 1'b1, 1'b0},
                  {1'b1, 8'h20, 3'd3, 1'b1, 1'b0},
                  {1'b1, 8'h21, 3'd3, 1'b1, 1'b0}};
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, bus[k]);
            @(negedge clk);
            checks++;
            if (obs !== exp_v[k]) begin
                failures++;
                $display("FAIL drain_wrap[%0d]: got %h expected %h", k, obs, exp_v[k]);
            end
            next_cycle();
        end
    endtask

    // Mid-stream reset, refill two bytes, then steal the bus while decode drains.
    task automatic test_bus_steal();
        logic [13:0] exp_v [7];
        logic [6:0]  rst_v, breq_v, fsup_v, rdy_v;
        logic [7:0]  bus [7];
        rst_v  = 7'b0000001;
        breq_v = 7'b0111000;
        fsup_v = 7'b1000000;
        rdy_v  = 7'b1111000;
        bus    = '{8'h99, 8'h30, 8'h31, 8'h32, 8'h32, 8'h32, 8'h32};
        exp_v  = '{{1'b0, 8'h00, 3'd0, 1'b0, 1'b0},
                   {BYP, BYP ? 8'h30 : 8'h00, 3'd0, 1'b1, 1'b0},
                   {1'b1, 8'h30, 3'd1, 1'b1, 1'b0},
                   {1'b1, 8'h30, 3'd2, 1'b0, 1'b0},
                   {1'b1, 8'h31, 3'd1, 1'b0, 1'b0},
                   {1'b0, 8'h00, 3'd0, 1'b0, 1'b0},
                   {1'b0, 8'h00, 3'd0, 1'b0, 1'b0}};
        for (int k = 0; k < 7; k++) begin
            drive(rst_v[k], 1'b0, breq_v[k], fsup_v[k], 1'b0, rdy_v[k], bus[k]);
            @(negedge clk);
            checks++;
            if (obs !== exp_v[k]) begin
                failures++;
                $display("FAIL bus_steal[%0d]: got %h expected %h", k, obs, exp_v[k]);
            end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        logic [13:0] exp_v [5];
        logic [4:0]  fl_v, breq_v, rdy_v;
        logic [7:0]  bus [5];
        fl_v   = 5'b00100;
        breq_v = 5'b10000;
        rdy_v  = 5'b00100;
        bus    = '{8'h40, 8'h41, 8'h42, 8'h42, 8'h43};
        exp_v  = '{{BYP, BYP ? 8'h40 : 8'h00, 3'd0, 1'b0, 1'b1},
                   {1'b1, 8'h40, 3'd1, 1'b0, 1'b1},
                   {1'b1, 8'h40, 3'd2, 1'b0, 1'b0},
                   {BYP, BYP ? 8'h42 : 8'h00, 3'd0, 1'b0, 1'b1},
                   {1'b1, 8'h42, 3'd1, 1'b0, 1'b0}};
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, fl_v[k], breq_v[k], 1'b0, 1'b1, rdy_v[k], bus[k]);
            @(negedge clk);
            checks++;
            if (obs !== exp_v[k]) begin
                failures++;
                $display("FAIL flush[%0d]: got %h expected %h", k, obs, exp_v[k]);
            end
            next_cycle();
        end
    endtask

    task automatic test_bypass();
        logic [13:0] exp_v [4];
        logic [3:0]  rst_v, breq_v;
        logic [7:0]  bus [4];
        rst_v  = 4'b0001;
        breq_v = 4'b1100;
        bus    = '{8'h00, 8'h3C, 8'h3D, 8'h3D};
        exp_v  = '{{1'b0, 8'h00, 3'd0, 1'b0, 1'b0},
                   {BYP, BYP ? 8'h3C : 8'h00, 3'd0, 1'b1, 1'b0},
                   {!BYP, BYP ? 8'h00 : 8'h3C, BYP ? 3'd0 : 3'd1, 1'b0, 1'b0},
                   {1'b0, 8'h00, 3'd0, 1'b0, 1'b0}};
        for (int k = 0; k < 4; k++) begin
            drive(rst_v[k], 1'b0, breq_v[k], 1'b0, 1'b0, 1'b1, bus[k]);
            @(negedge clk);
            checks++;
            if (obs !== exp_v[k]) begin
                failures++;
                $display("FAIL bypass[%0d]: got %h expected %h", k, obs, exp_v[k]);
            end
            next_cycle();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fill_stall();
        test_drain_wrap();
        test_bus_steal();
        test_flush();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
